// File: rtl/ecc_mul_arbiter_if.sv
// Signal bundle between ecc_mul_arbiter (slave) and its requesters, shared multiplier and status consumers (master).
interface ecc_mul_arbiter_if #(
  parameter int M = 233
);
  logic         REQ0;
  logic         REQ1;
  logic [M-1:0] A0;
  logic [M-1:0] B0;
  logic [M-1:0] A1;
  logic [M-1:0] B1;
  logic         GNT0;
  logic         GNT1;
  logic         DONE0;
  logic         DONE1;
  logic [M-1:0] RESULT;
  logic [M-1:0] MUL_A;
  logic [M-1:0] MUL_B;
  logic         MUL_IN_VALID;
  logic         MUL_OUT_VALID;
  logic [M-1:0] MUL_RESULT;
  logic         BUSY;
  logic         OWNER;
  logic [7:0]   OP_COUNT;
  logic         ERR;
  logic [1:0]   ARB_STATE;

  modport slave (
    input  REQ0, REQ1, A0, B0, A1, B1, MUL_OUT_VALID, MUL_RESULT,
    output GNT0, GNT1, DONE0, DONE1, RESULT, MUL_A, MUL_B, MUL_IN_VALID,
           BUSY, OWNER, OP_COUNT, ERR, ARB_STATE
  );

  modport master (
    output REQ0, REQ1, A0, B0, A1, B1, MUL_OUT_VALID, MUL_RESULT,
    input  GNT0, GNT1, DONE0, DONE1, RESULT, MUL_A, MUL_B, MUL_IN_VALID,
           BUSY, OWNER, OP_COUNT, ERR, ARB_STATE
  );
endinterface

// File: rtl/ecc_mul_arbiter.sv
// Round-robin share of one GF(2^M) multiplier between point-double (0) and point-add (1); GNT one cycle after REQ, DONE one after MUL_OUT_VALID.
// Define ECC_MUL_ARB_TIMEOUT_EN to bound WAIT at TO_MAX cycles with a sticky ERR; otherwise WAIT is unbounded and ERR is 0.
module ecc_mul_arbiter #(
  parameter int M      = 233,
  parameter int TO_MAX = 255
) (
  input logic              CLK,
  input logic              RST,
  ecc_mul_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } arb_state_t;

  arb_state_t   state;
  arb_state_t   state_nxt;
  logic         owner;
  logic         prio;
  logic         winner;
  logic         take;
  logic         timeout;
  logic [M-1:0] op_a;
  logic [M-1:0] op_b;
  logic [M-1:0] result;
  logic [7:0]   op_count;
  logic         err;

  // prio names the requester that wins a tie: the one not served last.
  assign winner = (bus.REQ0 && bus.REQ1) ? prio : bus.REQ1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    take             = 1'b0;
    bus.GNT0         = 1'b0;
    bus.GNT1         = 1'b0;
    bus.DONE0        = 1'b0;
    bus.DONE1        = 1'b0;
    bus.MUL_IN_VALID = 1'b0;
    bus.BUSY         = (state != IDLE);
    case (state)
      IDLE: begin
        if (bus.REQ0 || bus.REQ1) begin
          state_nxt = ISSUE;
          take      = 1'b1;
        end
      end
      ISSUE: begin
        bus.MUL_IN_VALID = 1'b1;
        bus.GNT0         = ~owner;
        bus.GNT1         = owner;
        state_nxt        = WAIT;
      end
      WAIT: begin
        if (bus.MUL_OUT_VALID) begin
          state_nxt = RESP;
        end else if (timeout) begin
          state_nxt = IDLE;
        end
      end
      RESP: begin
        bus.DONE0 = ~owner;
        bus.DONE1 = owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      owner    <= 1'b0;
      prio     <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      result   <= '0;
      op_count <= '0;
    end else begin
      if (take) begin
        owner <= winner;
        op_a  <= winner ? bus.A1 : bus.A0;
        op_b  <= winner ? bus.B1 : bus.B0;
      end
      if (state == WAIT && bus.MUL_OUT_VALID) begin
        result <= bus.MUL_RESULT;
      end
      if (state == RESP) begin
        op_count <= op_count + 8'd1;
        prio     <= ~owner;
      end else if (state == WAIT && !bus.MUL_OUT_VALID && timeout) begin
        prio <= ~owner;
      end
    end
  end

`ifdef ECC_MUL_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TO_MAX - 1);

  logic [7:0] to_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      to_cnt <= '0;
      err    <= 1'b0;
    end else begin
      to_cnt <= (state == WAIT) ? to_cnt + 8'd1 : 8'd0;
      if (state == WAIT && !bus.MUL_OUT_VALID && timeout) begin
        err <= 1'b1;
      end
    end
  end

  // Fires on the TO_MAX-th consecutive WAIT cycle.
  assign timeout = (state == WAIT) && (to_cnt == TO_LAST);
`else
  logic unused_to_max;
  assign unused_to_max = ^TO_MAX;
  assign timeout       = 1'b0;
  assign err           = 1'b0;
`endif

  assign bus.RESULT    = result;
  assign bus.MUL_A     = op_a;
  assign bus.MUL_B     = op_b;
  assign bus.OWNER     = owner;
  assign bus.OP_COUNT  = op_count;
  assign bus.ERR       = err;
  assign bus.ARB_STATE = state;

  assert property (@(posedge CLK) disable iff (RST)
    $onehot0({bus.GNT0, bus.GNT1, bus.DONE0, bus.DONE1}));

  assert property (@(posedge CLK) disable iff (RST)
    (state == WAIT) |-> ($stable(op_a) && $stable(op_b)));

endmodule

// File: tb/tb_ecc_mul_arbiter.sv
// Bench for ecc_mul_arbiter: vector table, randomized operations against a transaction-level model, and corner sequences.
module tb_ecc_mul_arbiter;
  localparam int M      = 233;
  localparam int TO_MAX = 255;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  ecc_mul_arbiter_if #(.M(M)) bus ();
  ecc_mul_arbiter #(.M(M), .TO_MAX(TO_MAX)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  typedef struct {
    logic         r0;
    logic         r1;
    logic [M-1:0] a0;
    logic [M-1:0] b0;
    logic [M-1:0] a1;
    logic [M-1:0] b1;
    int           dly;
    logic [M-1:0] res;
    logic         own;
  } vec_t;

  int           checks   = 0;
  int           passed   = 0;
  int           ops      = 0;     // model: completed operations mod 256
  logic         last     = 1'b1;  // model: last served (1 after reset so requester 0 wins ties)
  logic [M-1:0] last_res = '0;

  // Multiplier stand-in: answers mul_delay cycles after the first WAIT cycle; -1 never answers.
  int           mul_delay = 0;
  logic [M-1:0] mul_val   = '0;
  logic         spur      = 1'b0;
  int           mcnt      = 0;

  initial begin
    bus.MUL_OUT_VALID = 1'b0;
    bus.MUL_RESULT    = '0;
    forever begin
      @(negedge CLK);
      bus.MUL_OUT_VALID = 1'b0;
      if (bus.MUL_IN_VALID && mul_delay >= 0) begin
        mcnt = mul_delay + 1;
      end else if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          bus.MUL_OUT_VALID = 1'b1;
          bus.MUL_RESULT    = mul_val;
        end
      end
      if (spur) begin
        bus.MUL_OUT_VALID = 1'b1;
        bus.MUL_RESULT    = mul_val;
        spur              = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [M-1:0] act, input logic [M-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic chki(input string name, input integer act, input integer exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d want %0d", name, act, exp);
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b want %b", name, act, exp);
  endtask

  function automatic logic [M-1:0] rnd_m();
    logic [M-1:0] v;
    v = '0;
    for (int i = 0; i < M; i += 32) v = (v << 32) | M'($urandom());
    return v;
  endfunction

  function automatic vec_t mk(input logic r0, input logic r1,
                              input logic [M-1:0] a0, input logic [M-1:0] b0,
                              input logic [M-1:0] a1, input logic [M-1:0] b1,
                              input int dly, input logic [M-1:0] res, input logic own);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.a0 = a0; v.b0 = b0; v.a1 = a1; v.b1 = b1;
    v.dly = dly; v.res = res; v.own = own;
    return v;
  endfunction

  task automatic do_reset();
    RST      = 1'b1;
    bus.REQ0 = 1'b0;
    bus.REQ1 = 1'b0;
    repeat (3) @(negedge CLK);
    RST      = 1'b0;
    ops      = 0;
    last     = 1'b1;
    last_res = '0;
    @(negedge CLK);
  endtask

  // One complete operation, started from IDLE; requests drop once granted.
  task automatic run_op(input string tag, input vec_t v);
    int   n;
    int   stray;
    logic seen;
    bus.REQ0 = v.r0; bus.REQ1 = v.r1;
    bus.A0 = v.a0; bus.B0 = v.b0; bus.A1 = v.a1; bus.B1 = v.b1;
    mul_delay = v.dly;
    mul_val   = v.res;
    n = 0; seen = 1'b0;
    while (!seen && n < 10) begin
      @(negedge CLK);
      n++;
      seen = bus.GNT0 | bus.GNT1;
    end
    chki({tag, " grant latency"}, n, 1);
    chkb({tag, " GNT0"}, bus.GNT0, !v.own);
    chkb({tag, " GNT1"}, bus.GNT1, v.own);
    chkb({tag, " MUL_IN_VALID"}, bus.MUL_IN_VALID, 1'b1);
    chkb({tag, " OWNER"}, bus.OWNER, v.own);
    chk({tag, " MUL_A"}, bus.MUL_A, v.own ? v.a1 : v.a0);
    chk({tag, " MUL_B"}, bus.MUL_B, v.own ? v.b1 : v.b0);
    bus.REQ0 = 1'b0;
    bus.REQ1 = 1'b0;
    n = 0; seen = 1'b0; stray = 0;
    while (!seen && n < v.dly + 12) begin
      @(negedge CLK);
      n++;
      seen = bus.DONE0 | bus.DONE1;
      if (bus.GNT0 || bus.GNT1) stray++;
    end
    chki({tag, " done latency"}, n, v.dly + 2);
    chkb({tag, " DONE0"}, bus.DONE0, !v.own);
    chkb({tag, " DONE1"}, bus.DONE1, v.own);
    chk({tag, " RESULT"}, bus.RESULT, v.res);
    chk({tag, " MUL_A held"}, bus.MUL_A, v.own ? v.a1 : v.a0);
    chki({tag, " stray grants"}, stray, 0);
    @(negedge CLK);
    ops      = (ops + 1) % 256;
    last     = v.own;
    last_res = v.res;
    chki({tag, " OP_COUNT"}, 32'(bus.OP_COUNT), ops);
    chkb({tag, " BUSY after"}, bus.BUSY, 1'b0);
  endtask

  vec_t tbl[8];

  initial begin
    int   n;
    int   dn;
    int   gn;
    int   errly;
    int   gcnt;
    int   gord[4];
    int   gtime[4];

    tbl[0] = mk(1, 0, M'(1), M'(2), M'(0), M'(0), 10, M'(2), 0);
    tbl[1] = mk(1, 1, M'(3), M'(5), M'(7), M'(11), 0, M'('h15), 1);
    tbl[2] = mk(1, 1, M'('h1234), M'('h5678), M'('h9abc), M'('hdef0), 3, M'('hcafe), 0);
    tbl[3] = mk(0, 1, M'(0), M'(0), M'('h55), M'('haa), 5, M'('hbeef), 1);
    tbl[4] = mk(1, 1, M'('h11), M'('h22), M'('h33), M'('h44), 1, M'('h77), 0);
    tbl[5] = mk(1, 0, M'('hff), M'(1), M'(2), M'(3), 2, M'('h100), 0);
    tbl[6] = mk(1, 1, M'('ha), M'('hb), M'('hc), M'('hd), 0, M'('he), 1);
    tbl[7] = mk(0, 1, M'(5), M'(6), M'(7), M'(8), 4, ~M'(0), 1);

    bus.REQ0 = 1'b0; bus.REQ1 = 1'b0;
    bus.A0 = '0; bus.B0 = '0; bus.A1 = '0; bus.B1 = '0;

    // Reset state, observed while RST is still held.
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chki("rst ARB_STATE", 32'(bus.ARB_STATE), 0);
    chkb("rst BUSY", bus.BUSY, 1'b0);
    chkb("rst GNT0", bus.GNT0, 1'b0);
    chkb("rst GNT1", bus.GNT1, 1'b0);
    chkb("rst DONE0", bus.DONE0, 1'b0);
    chkb("rst DONE1", bus.DONE1, 1'b0);
    chkb("rst MUL_IN_VALID", bus.MUL_IN_VALID, 1'b0);
    chkb("rst OWNER", bus.OWNER, 1'b0);
    chkb("rst ERR", bus.ERR, 1'b0);
    chki("rst OP_COUNT", 32'(bus.OP_COUNT), 0);
    chk("rst RESULT", bus.RESULT, '0);
    chk("rst MUL_A", bus.MUL_A, '0);
    chk("rst MUL_B", bus.MUL_B, '0);
    RST = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 8; i++) run_op($sformatf("vec%0d", i), tbl[i]);

    // MUL_OUT_VALID while IDLE must be ignored.
    mul_val = M'('h9999);
    spur    = 1'b1;
    dn      = 0;
    repeat (3) begin
      @(negedge CLK);
      if (bus.DONE0 || bus.DONE1) dn++;
    end
    chki("spurious done", dn, 0);
    chki("spurious state", 32'(bus.ARB_STATE), 0);
    chk("spurious RESULT", bus.RESULT, last_res);

    for (int i = 0; i < 40; i++) begin
      vec_t v;
      int   r;
      r     = int'($urandom_range(1, 3));
      v.r0  = r[0];
      v.r1  = r[1];
      v.a0  = rnd_m(); v.b0 = rnd_m(); v.a1 = rnd_m(); v.b1 = rnd_m();
      v.dly = int'($urandom_range(0, 6));
      v.res = rnd_m();
      v.own = (v.r0 && v.r1) ? !last : v.r1;
      run_op($sformatf("rnd%0d", i), v);
    end

    // Both requesters held: alternating grants, back-to-back at 4-cycle spacing.
    do_reset();
    bus.A0 = M'('h10); bus.B0 = M'('h20); bus.A1 = M'('h30); bus.B1 = M'('h40);
    mul_delay = 0;
    mul_val   = M'('h5a5a);
    bus.REQ0  = 1'b1;
    bus.REQ1  = 1'b1;
    gcnt = 0; dn = 0; n = 0;
    while (dn < 4 && n < 60) begin
      @(negedge CLK);
      n++;
      if ((bus.GNT0 || bus.GNT1) && gcnt < 4) begin
        gord[gcnt]  = bus.GNT1 ? 1 : 0;
        gtime[gcnt] = n;
        gcnt++;
        if (gcnt == 4) begin
          bus.REQ0 = 1'b0;
          bus.REQ1 = 1'b0;
        end
      end
      if (bus.DONE0 || bus.DONE1) dn++;
    end
    chki("rr grants", gcnt, 4);
    chki("rr dones", dn, 4);
    for (int k = 0; k < 4; k++) chki($sformatf("rr order %0d", k), gord[k], k % 2);
    for (int k = 1; k < 4; k++) chki($sformatf("rr spacing %0d", k), gtime[k] - gtime[k-1], 4);
    @(negedge CLK);
    chki("rr OP_COUNT", 32'(bus.OP_COUNT), 4);
    chkb("rr BUSY", bus.BUSY, 1'b0);

    // Reset while waiting on the multiplier; its late answer must not complete anything.
    bus.REQ0 = 1'b1;
    bus.A0 = rnd_m(); bus.B0 = rnd_m();
    mul_delay = 8;
    mul_val   = rnd_m();
    n = 0;
    while (!bus.GNT0 && n < 10) begin
      @(negedge CLK);
      n++;
    end
    chki("rstwait grant latency", n, 1);
    bus.REQ0 = 1'b0;
    repeat (3) @(negedge CLK);
    chki("rstwait in WAIT", 32'(bus.ARB_STATE), 2);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    ops = 0; last = 1'b1; last_res = '0;
    dn = 0; gn = 0;
    repeat (20) begin
      @(negedge CLK);
      if (bus.DONE0 || bus.DONE1) dn++;
      if (bus.GNT0 || bus.GNT1) gn++;
    end
    chki("rstwait dones", dn, 0);
    chki("rstwait grants", gn, 0);
    chki("rstwait state", 32'(bus.ARB_STATE), 0);
    chki("rstwait OP_COUNT", 32'(bus.OP_COUNT), 0);
    chk("rstwait RESULT", bus.RESULT, '0);
    chk("rstwait MUL_A", bus.MUL_A, '0);
    run_op("rstwait prio", mk(1, 1, M'('h61), M'('h62), M'('h63), M'('h64), 1, M'('h65), 0));

    // OP_COUNT wrap after 256 completions.
    do_reset();
    bus.A0 = M'('h3); bus.B0 = M'('h4);
    mul_delay = 0;
    mul_val   = M'('h42);
    bus.REQ0  = 1'b1;
    dn = 0; n = 0; gn = 0;
    while (dn < 256 && n < 1100) begin
      @(negedge CLK);
      n++;
      if (gn == 1) begin
        chki("wrap OP_COUNT 255", 32'(bus.OP_COUNT), 255);
        gn = 2;
      end
      if (bus.DONE0) begin
        dn++;
        if (dn == 255) gn = 1;
        if (dn == 256) bus.REQ0 = 1'b0;
      end
    end
    bus.REQ0 = 1'b0;
    chki("wrap dones", dn, 256);
    @(negedge CLK);
    chki("wrap OP_COUNT 0", 32'(bus.OP_COUNT), 0);
    ops = 0; last = 1'b0; last_res = M'('h42);

    // Multiplier never answers.
    bus.REQ0  = 1'b1;
    mul_delay = -1;
    n = 0;
    while (!bus.GNT0 && n < 10) begin
      @(negedge CLK);
      n++;
    end
    chki("tmo grant latency", n, 1);
    bus.REQ0 = 1'b0;
`ifdef ECC_MUL_ARB_TIMEOUT_EN
    n = 0; dn = 0; errly = 0;
    while (bus.BUSY && n < 400) begin
      @(negedge CLK);
      n++;
      if (bus.DONE0 || bus.DONE1) dn++;
      if (bus.BUSY && bus.ERR) errly++;
    end
    chki("tmo wait cycles", n, TO_MAX + 1);
    chkb("tmo ERR", bus.ERR, 1'b1);
    chki("tmo dones", dn, 0);
    chki("tmo early ERR", errly, 0);
    chkb("tmo BUSY", bus.BUSY, 1'b0);
    chk("tmo RESULT", bus.RESULT, last_res);
    run_op("tmo prio", mk(1, 1, M'('h71), M'('h72), M'('h73), M'('h74), 0, M'('h75), 1));
    chkb("tmo ERR sticky", bus.ERR, 1'b1);
`else
    dn = 0;
    repeat (300) begin
      @(negedge CLK);
      if (bus.DONE0 || bus.DONE1) dn++;
    end
    chki("notmo dones", dn, 0);
    chkb("notmo ERR", bus.ERR, 1'b0);
    chki("notmo state", 32'(bus.ARB_STATE), 2);
    chkb("notmo BUSY", bus.BUSY, 1'b1);
    errly = 0;
    do_reset();
    chki("notmo reset state", 32'(bus.ARB_STATE), errly);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
